vfft_frame_ctrl: RTL
====================

// Module: vfft_frame_ctrl
// PURPOSE
//  Sequencer for the velocity (Doppler) FFT core. Latches sample_num/chirp_num on a config trigger.
//  Drives the FFT core's AXI-S config channel (NFFT) and gates the corner-turned input stream.
//  Generates per-transform tlast (every chirp_num samples) and counts output samples to mark frame end.
//  Sits between the corner-turn buffer and the vfft core/rdmap power stage.
// PARAMETERS
//  MAX_BINS   2048   max range bins per frame (sample_num upper bound)
//  CNT_W      24     width of frame sample counters (>= log2(MAX_BINS*128))
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  sample_num     in   16  range bins per frame (number of FFTs)
//  chirp_num      in   16  chirps per frame (FFT length: 32/64/128)
//  config_trigger in   1   level; rising edge starts config+frame
//  cfg_tdata      out  16  FFT config word {8'd1, log2(chirp_num)}
//  cfg_tvalid     out  1   config valid
//  cfg_tready     in   1   config ready from FFT core
//  in_data        in   32  corner-turned sample {im16,re16}
//  in_valid       in   1   upstream valid
//  in_ready       out  1   upstream ready
//  fft_tdata      out  32  to FFT s_axis_data_tdata (= in_data)
//  fft_tvalid     out  1   to FFT s_axis_data_tvalid
//  fft_tlast      out  1   to FFT s_axis_data_tlast
//  fft_tready     in   1   from FFT s_axis_data_tready
//  fft_out_valid  in   1   FFT m_axis_data_tvalid (tready tied 1)
//  frame_last     out  1   1-cycle pulse with final FFT output sample of frame
//  busy           out  1   state != IDLE
//  cfg_err        out  1   sticky: unsupported chirp_num; cleared on next accepted trigger
//  trig_ignored   out  1   1-cycle pulse: trigger edge seen while not IDLE
// BEHAVIOUR
//  Reset: state=IDLE; cfg_tdata=0, cfg_err=0, all valid/pulse outputs 0; counters 0.
//  Trigger edge: registered trigger compared to its previous value; edge = cur & ~prev (1-cycle lag).
//  FSM:
//   IDLE  -- edge --> CHECK: latch sample_num/chirp_num, clear cfg_err.
//   CHECK -- chirp_num in {32,64,128} --> CFG, cfg_tdata={8'd1,8'd5/6/7}; else --> IDLE, cfg_err=1.
//   CHECK -- sample_num==0 or >MAX_BINS --> IDLE, cfg_err=1.
//   CFG   cfg_tvalid=1 held until cfg_tready; on handshake --> RUN.
//   RUN   in_ready=fft_tready; fft_tvalid=in_valid (combinational, only in RUN).
//         Input beat = in_valid&fft_tready; chirp_cnt counts 0..chirp_num-1 and wraps.
//         fft_tlast=(chirp_cnt==chirp_num-1); on tlast beat bin_cnt++.
//         Tlast beat with bin_cnt==sample_num-1 --> DRAIN; no further input accepted.
//   DRAIN out_cnt counts fft_out_valid cycles (out_cnt runs from RUN entry).
//         On beat out_cnt==sample_num*chirp_num-1: frame_last=1 (registered, 1 cycle after that beat) --> IDLE.
//  Output beats during RUN also count; output may overlap input.
//  Outside RUN: in_ready=0, fft_tvalid=0, fft_tlast=0; fft_tdata always = in_data.
//  Width: product sample_num*chirp_num computed once in CHECK into CNT_W bits (max 2048*128=2^18).
//  Trigger edge in any state other than IDLE: ignored, trig_ignored pulses; frame continues.
//  fft_out_valid in IDLE/CHECK/CFG: ignored, not counted.
//  rst mid-frame: immediate return to IDLE, all counters cleared, cfg_tvalid drops; FFT core reset separately.
//  Config latched values stable for the frame; input port changes mid-frame have no effect.
// STRUCTURE
//  Package vfft_pkg: state enum (IDLE,CHECK,CFG,RUN,DRAIN), NFFT codes (5/6/7), CFG_FWD=8'd1.
//  Single module; no sub-module (counters+FSM only). Expected ~200 lines.
// TESTING
//  1 sample_num=4, chirp_num=32, trigger edge, cfg_tready=1 -> cfg_tdata=16'h0105, 1 cfg beat, RUN.
//  2 Stream 128 beats, fft_tready=1 -> fft_tlast on beats 31,63,95,127; DRAIN after beat 127.
//  3 Feed 128 fft_out_valid -> frame_last pulses 1 cycle after 128th; busy drops; IDLE.
//  4 chirp_num=48 -> cfg_err=1, no cfg_tvalid, IDLE; then chirp_num=64 trigger -> cfg_err=0, cfg_tdata=16'h0106.
//  5 fft_tready toggling 50% with chirp_num=128, sample_num=2 -> in_ready tracks fft_tready.
//     Exactly 256 beats; tlast on 128th and 256th.
//  6 Trigger edge during RUN -> trig_ignored pulse, counts unaffected; rst mid-RUN -> IDLE, counters 0.

Source files
------------

// File: rtl/vfft_pkg.sv
// Shared types and constants for the velocity-FFT frame sequencer.
// Holds the FSM state encoding, the NFFT codes and the config-word lookup.
package vfft_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_CFG   = 3'd2,
        ST_RUN   = 3'd3,
        ST_DRAIN = 3'd4
    } vfft_state_e;

    localparam logic [7:0] NFFT_32  = 8'd5;
    localparam logic [7:0] NFFT_64  = 8'd6;
    localparam logic [7:0] NFFT_128 = 8'd7;
    localparam logic [7:0] CFG_FWD  = 8'd1;

    // Returns {supported, nfft_code}; supported is 0 for any other FFT length.
    function automatic logic [8:0] nfft_lookup(input logic [15:0] chirp);
        logic [8:0] res;
        case (chirp)
            16'd32:  res = {1'b1, NFFT_32};
            16'd64:  res = {1'b1, NFFT_64};
            16'd128: res = {1'b1, NFFT_128};
            default: res = {1'b0, 8'd0};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/vfft_frame_ctrl.sv
// Frame sequencer for the Doppler FFT core: validates and issues the FFT config,
// gates the corner-turned stream with per-transform tlast and marks frame end.
module vfft_frame_ctrl
    import vfft_pkg::*;
#(
    parameter int MAX_BINS = 2048,
    parameter int CNT_W    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample_num,
    input  logic [15:0] chirp_num,
    input  logic        config_trigger,
    output logic [15:0] cfg_tdata,
    output logic        cfg_tvalid,
    input  logic        cfg_tready,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] fft_tdata,
    output logic        fft_tvalid,
    output logic        fft_tlast,
    input  logic        fft_tready,
    input  logic        fft_out_valid,
    output logic        frame_last,
    output logic        busy,
    output logic        cfg_err,
    output logic        trig_ignored
);

    vfft_state_e state_q, state_d;
    logic              trig_q, trig_prev_q;
    logic [15:0]       sample_q, sample_d;
    logic [15:0]       chirp_q, chirp_d;
    logic [CNT_W-1:0]  total_q, total_d;
    logic [15:0]       chirp_cnt_q, chirp_cnt_d;
    logic [15:0]       bin_cnt_q, bin_cnt_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic [15:0]       cfg_tdata_q, cfg_tdata_d;
    logic              cfg_err_q, cfg_err_d;
    logic              frame_last_q, frame_last_d;
    logic              trig_ignored_q, trig_ignored_d;

    logic              trig_edge_s;
    logic [8:0]        nfft_s;
    logic [CNT_W-1:0]  prod_s;
    logic              tlast_s;
    logic              in_beat_s;
    logic              out_hit_s;
    logic              size_bad_s;

    assign trig_edge_s = trig_q & ~trig_prev_q;
    assign nfft_s      = nfft_lookup(chirp_q);
    assign prod_s      = CNT_W'(sample_q) * CNT_W'(chirp_q);
    assign tlast_s     = (chirp_cnt_q == (chirp_q - 16'd1));
    assign in_beat_s   = in_valid & fft_tready;
    assign out_hit_s   = (out_cnt_q == (total_q - CNT_W'(1)));
    assign size_bad_s  = (sample_q == 16'd0) || (sample_q > 16'(MAX_BINS));

    assign fft_tdata    = in_data;
    assign cfg_tdata    = cfg_tdata_q;
    assign cfg_err      = cfg_err_q;
    assign frame_last   = frame_last_q;
    assign trig_ignored = trig_ignored_q;
    assign busy         = (state_q != ST_IDLE);

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d        = state_q;
        sample_d       = sample_q;
        chirp_d        = chirp_q;
        total_d        = total_q;
        chirp_cnt_d    = chirp_cnt_q;
        bin_cnt_d      = bin_cnt_q;
        out_cnt_d      = out_cnt_q;
        cfg_tdata_d    = cfg_tdata_q;
        cfg_err_d      = cfg_err_q;
        frame_last_d   = 1'b0;
        trig_ignored_d = trig_edge_s && (state_q != ST_IDLE);
        cfg_tvalid     = 1'b0;
        in_ready       = 1'b0;
        fft_tvalid     = 1'b0;
        fft_tlast      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (trig_edge_s) begin
                    sample_d    = sample_num;
                    chirp_d     = chirp_num;
                    cfg_err_d   = 1'b0;
                    chirp_cnt_d = 16'd0;
                    bin_cnt_d   = 16'd0;
                    out_cnt_d   = '0;
                    state_d     = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!nfft_s[8] || size_bad_s) begin
                    cfg_err_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    cfg_tdata_d = {CFG_FWD, nfft_s[7:0]};
                    total_d     = prod_s;
                    state_d     = ST_CFG;
                end
            end
            ST_CFG: begin
                cfg_tvalid = 1'b1;
                if (cfg_tready) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_CFG;
                end
            end
            ST_RUN: begin
                in_ready   = fft_tready;
                fft_tvalid = in_valid;
                fft_tlast  = tlast_s;
                // FFT output can start before the last input beat, so count it here too.
                if (fft_out_valid) begin
                    out_cnt_d = out_cnt_q + CNT_W'(1);
                end else begin
                    out_cnt_d = out_cnt_q;
                end
                if (in_beat_s) begin
                    if (tlast_s) begin
                        chirp_cnt_d = 16'd0;
                        bin_cnt_d   = bin_cnt_q + 16'd1;
                        if (bin_cnt_q == (sample_q - 16'd1)) begin
                            state_d = ST_DRAIN;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        chirp_cnt_d = chirp_cnt_q + 16'd1;
                    end
                end else begin
                    chirp_cnt_d = chirp_cnt_q;
                end
            end
            ST_DRAIN: begin
                if (fft_out_valid) begin
                    if (out_hit_s) begin
                        frame_last_d = 1'b1;
                        out_cnt_d    = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        out_cnt_d = out_cnt_q + CNT_W'(1);
                    end
                end else begin
                    out_cnt_d = out_cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; rst abandons any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            trig_q         <= 1'b0;
            trig_prev_q    <= 1'b0;
            sample_q       <= 16'd0;
            chirp_q        <= 16'd0;
            total_q        <= '0;
            chirp_cnt_q    <= 16'd0;
            bin_cnt_q      <= 16'd0;
            out_cnt_q      <= '0;
            cfg_tdata_q    <= 16'd0;
            cfg_err_q      <= 1'b0;
            frame_last_q   <= 1'b0;
            trig_ignored_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            trig_q         <= config_trigger;
            trig_prev_q    <= trig_q;
            sample_q       <= sample_d;
            chirp_q        <= chirp_d;
            total_q        <= total_d;
            chirp_cnt_q    <= chirp_cnt_d;
            bin_cnt_q      <= bin_cnt_d;
            out_cnt_q      <= out_cnt_d;
            cfg_tdata_q    <= cfg_tdata_d;
            cfg_err_q      <= cfg_err_d;
            frame_last_q   <= frame_last_d;
            trig_ignored_q <= trig_ignored_d;
        end
    end

endmodule
